// File: rtl/core_arb_pkg.sv
// Shared encodings for the L1 fetch/data arbiter: operation and size codes, FSM states, owner ids.
package core_arb_pkg;

    localparam int unsigned CORE_COP_W  = 3;
    localparam int unsigned CORE_SIZE_W = 3;

    localparam logic [CORE_COP_W-1:0] CORE_COP_RD = 3'd0;
    localparam logic [CORE_COP_W-1:0] CORE_COP_WR = 3'd1;

    localparam logic [CORE_SIZE_W-1:0] CORE_SIZE_B = 3'd0;
    localparam logic [CORE_SIZE_W-1:0] CORE_SIZE_H = 3'd1;
    localparam logic [CORE_SIZE_W-1:0] CORE_SIZE_W_ = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Unknown operation codes are issued to memory as reads.
    function automatic logic [CORE_COP_W-1:0] core_cop_norm(input logic [CORE_COP_W-1:0] cop);
        return (cop == CORE_COP_WR) ? CORE_COP_WR : CORE_COP_RD;
    endfunction

endpackage

// File: rtl/core_nc_chk.sv
// Non-cacheable window compare: address falls in the window when its masked bits equal the masked base.
module core_nc_chk #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] mask,
    output logic              nc_c
);

    assign nc_c = ((addr & mask) == (base & mask));

endmodule

// File: rtl/core_l1_arb.sv
// Shares one memory request port between the fetch (l1i) and load/store (l1d) channels, one
// transaction at a time. Define CORE_ARB_RR_EN for round-robin ties; default is data-over-fetch.
module core_l1_arb
    import core_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            csr_nc_base,
    input  logic [31:0]            csr_nc_mask,
    input  logic                   l1i_req_val,
    input  logic [ADDR_W-1:0]      l1i_req_addr,
    output logic                   l1i_ack,
    output logic [DATA_W-1:0]      l1i_ack_rdata,
    input  logic                   l1d_req_val,
    input  logic [ADDR_W-1:0]      l1d_req_addr,
    input  logic [CORE_COP_W-1:0]  l1d_req_cop,
    input  logic [DATA_W-1:0]      l1d_req_wdata,
    input  logic [CORE_SIZE_W-1:0] l1d_req_size,
    output logic                   l1d_ack,
    output logic [DATA_W-1:0]      l1d_ack_rdata,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [ADDR_W-1:0]      mem_req_addr,
    output logic [CORE_COP_W-1:0]  mem_req_cop,
    output logic [DATA_W-1:0]      mem_req_wdata,
    output logic [CORE_SIZE_W-1:0] mem_req_size,
    output logic                   mem_req_nc,
    input  logic                   mem_ack_val,
    input  logic [DATA_W-1:0]      mem_ack_rdata
);

    arb_state_t             state_q, state_d;
    arb_owner_t             owner_q, owner_d;
    arb_owner_t             win_c;
    logic [ADDR_W-1:0]      win_addr_c;
    logic                   win_nc_c;

    logic                   req_val_d;
    logic [ADDR_W-1:0]      req_addr_d;
    logic [CORE_COP_W-1:0]  req_cop_d;
    logic [DATA_W-1:0]      req_wdata_d;
    logic [CORE_SIZE_W-1:0] req_size_d;
    logic                   req_nc_d;
    logic                   i_ack_d, d_ack_d;
    logic [DATA_W-1:0]      i_rdata_d, d_rdata_d;

`ifdef CORE_ARB_RR_EN
    arb_owner_t             rr_last_q, rr_last_d;

    // Tie goes to whichever channel was not granted last.
    always_comb begin : win_sel
        win_c = OWN_I;
        if (l1i_req_val && l1d_req_val) begin
            win_c = (rr_last_q == OWN_D) ? OWN_I : OWN_D;
        end else if (l1d_req_val) begin
            win_c = OWN_D;
        end
    end
`else
    always_comb begin : win_sel
        win_c = l1d_req_val ? OWN_D : OWN_I;
    end
`endif

    assign win_addr_c = (win_c == OWN_D) ? l1d_req_addr : l1i_req_addr;

    core_nc_chk #(
        .ADDR_W (ADDR_W)
    ) u_nc_chk (
        .addr (win_addr_c),
        .base (ADDR_W'(csr_nc_base)),
        .mask (ADDR_W'(csr_nc_mask)),
        .nc_c (win_nc_c)
    );

    // Next-state and next-output logic; request fields and rdata hold unless updated.
    always_comb begin : fsm_next
        state_d     = state_q;
        owner_d     = owner_q;
        req_val_d   = 1'b0;
        req_addr_d  = mem_req_addr;
        req_cop_d   = mem_req_cop;
        req_wdata_d = mem_req_wdata;
        req_size_d  = mem_req_size;
        req_nc_d    = mem_req_nc;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = l1i_ack_rdata;
        d_rdata_d   = l1d_ack_rdata;
`ifdef CORE_ARB_RR_EN
        rr_last_d   = rr_last_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (l1i_req_val || l1d_req_val) begin
                    owner_d    = win_c;
                    req_val_d  = 1'b1;
                    req_addr_d = win_addr_c;
                    req_nc_d   = win_nc_c;
                    if (win_c == OWN_D) begin
                        req_cop_d   = core_cop_norm(l1d_req_cop);
                        req_wdata_d = l1d_req_wdata;
                        req_size_d  = l1d_req_size;
                    end else begin
                        req_cop_d   = CORE_COP_RD;
                        req_wdata_d = '0;
                        req_size_d  = CORE_SIZE_W_;
                    end
`ifdef CORE_ARB_RR_EN
                    rr_last_d  = win_c;
`endif
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                req_val_d = 1'b1;
                if (mem_req_rdy) begin
                    req_val_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_ack_val) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_ack_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = mem_ack_rdata;
                        i_ack_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_I;
            mem_req_val   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_cop   <= '0;
            mem_req_wdata <= '0;
            mem_req_size  <= '0;
            mem_req_nc    <= 1'b0;
            l1i_ack       <= 1'b0;
            l1d_ack       <= 1'b0;
            l1i_ack_rdata <= '0;
            l1d_ack_rdata <= '0;
`ifdef CORE_ARB_RR_EN
            rr_last_q     <= OWN_D;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            mem_req_val   <= req_val_d;
            mem_req_addr  <= req_addr_d;
            mem_req_cop   <= req_cop_d;
            mem_req_wdata <= req_wdata_d;
            mem_req_size  <= req_size_d;
            mem_req_nc    <= req_nc_d;
            l1i_ack       <= i_ack_d;
            l1d_ack       <= d_ack_d;
            l1i_ack_rdata <= i_rdata_d;
            l1d_ack_rdata <= d_rdata_d;
`ifdef CORE_ARB_RR_EN
            rr_last_q     <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_core_l1_arb.sv
// Self-checking bench for core_l1_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_core_l1_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] csr_nc_base, csr_nc_mask;
    logic        l1i_req_val;
    logic [31:0] l1i_req_addr;
    logic        l1i_ack;
    logic [31:0] l1i_ack_rdata;
    logic        l1d_req_val;
    logic [31:0] l1d_req_addr;
    logic [2:0]  l1d_req_cop;
    logic [31:0] l1d_req_wdata;
    logic [2:0]  l1d_req_size;
    logic        l1d_ack;
    logic [31:0] l1d_ack_rdata;
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic [31:0] mem_req_addr;
    logic [2:0]  mem_req_cop;
    logic [31:0] mem_req_wdata;
    logic [2:0]  mem_req_size;
    logic        mem_req_nc;
    logic        mem_ack_val;
    logic [31:0] mem_ack_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_rr_d   = 1'b1;   // reference: last granted channel was data

    core_l1_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_nc_base(csr_nc_base), .csr_nc_mask(csr_nc_mask),
        .l1i_req_val(l1i_req_val), .l1i_req_addr(l1i_req_addr),
        .l1i_ack(l1i_ack), .l1i_ack_rdata(l1i_ack_rdata),
        .l1d_req_val(l1d_req_val), .l1d_req_addr(l1d_req_addr), .l1d_req_cop(l1d_req_cop),
        .l1d_req_wdata(l1d_req_wdata), .l1d_req_size(l1d_req_size),
        .l1d_ack(l1d_ack), .l1d_ack_rdata(l1d_ack_rdata),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_cop(mem_req_cop), .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size),
        .mem_req_nc(mem_req_nc), .mem_ack_val(mem_ack_val), .mem_ack_rdata(mem_ack_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        l1i_req_val = 0; l1i_req_addr = '0;
        l1d_req_val = 0; l1d_req_addr = '0; l1d_req_cop = 3'd0; l1d_req_wdata = '0; l1d_req_size = 3'd0;
        mem_req_rdy = 0; mem_ack_val = 0; mem_ack_rdata = '0;
    endtask

    // Reference arbitration choice: returns 1 when data wins.
    function automatic bit ref_pick_d(input bit iv, input bit dv);
        bit d;
`ifdef CORE_ARB_RR_EN
        d = (iv && dv) ? ~m_rr_d : dv;
        m_rr_d = d;
`else
        d = dv;
`endif
        return d;
    endfunction

    function automatic bit ref_nc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
        return ((a ^ b) & m) == 32'd0;
    endfunction

    task automatic do_reset();
        quiet_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        m_rr_d = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        quiet_inputs();
        csr_nc_base = 32'h8000_0000; csr_nc_mask = 32'hF000_0000;
        rst_n = 0;
        #3;
        n_checks++; if ({mem_req_val, l1i_ack, l1d_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl got %b exp 000", {mem_req_val, l1i_ack, l1d_ack}); end
        n_checks++; if ({mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size, mem_req_nc} !== '0) begin n_fail++; $display("FAIL reset_fields got addr=%h cop=%0d wdata=%h size=%0d nc=%b", mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size, mem_req_nc); end
        n_checks++; if ({l1i_ack_rdata, l1d_ack_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h %h exp 0", l1i_ack_rdata, l1d_ack_rdata); end
        tick(); tick();
        rst_n = 1;
        m_rr_d = 1'b1;
        tick(); tick();
        n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL reset_idle_val got %b exp 0", mem_req_val); end
    endtask

    task automatic test_fetch();
        l1i_req_val = 1; l1i_req_addr = 32'h0000_0100; mem_req_rdy = 1;
        tick();
        n_checks++; if ({mem_req_val, mem_req_size, mem_req_cop} !== {1'b1, 3'd2, 3'd0}) begin n_fail++; $display("FAIL fetch_req got val=%b size=%0d cop=%0d exp 1/2/0", mem_req_val, mem_req_size, mem_req_cop); end
        n_checks++; if ({mem_req_addr, mem_req_wdata, mem_req_nc} !== {32'h0000_0100, 32'd0, 1'b0}) begin n_fail++; $display("FAIL fetch_fields got addr=%h wdata=%h nc=%b", mem_req_addr, mem_req_wdata, mem_req_nc); end
        tick();
        n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL fetch_resp_val got %b exp 0", mem_req_val); end
        mem_ack_val = 1; mem_ack_rdata = 32'h0000_0013;
        tick();
        mem_ack_val = 0;
        n_checks++; if ({l1i_ack, l1d_ack, l1i_ack_rdata} !== {2'b10, 32'h0000_0013}) begin n_fail++; $display("FAIL fetch_ack got i=%b d=%b rdata=%h exp 1/0/00000013", l1i_ack, l1d_ack, l1i_ack_rdata); end
        l1i_req_val = 0;
        tick();
        n_checks++; if ({l1i_ack, l1d_ack, mem_req_val} !== 3'b000) begin n_fail++; $display("FAIL fetch_after got %b exp 000", {l1i_ack, l1d_ack, mem_req_val}); end
    endtask

    task automatic test_store_stall();
        l1d_req_val = 1; l1d_req_addr = 32'h0000_2004; l1d_req_cop = 3'd1;
        l1d_req_wdata = 32'hDEAD_BEEF; l1d_req_size = 3'd2; mem_req_rdy = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) mem_req_rdy = 1;
            n_checks++; if ({mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size} !== {1'b1, 32'h0000_2004, 3'd1, 32'hDEAD_BEEF, 3'd2}) begin
                n_fail++; $display("FAIL store_stall_%0d got val=%b addr=%h cop=%0d wdata=%h size=%0d", c, mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size);
            end
        end
        tick();
        n_checks++; if ({mem_req_val, l1i_ack, l1d_ack} !== 3'b000) begin n_fail++; $display("FAIL store_resp got %b exp 000", {mem_req_val, l1i_ack, l1d_ack}); end
        tick();
        n_checks++; if (l1d_ack !== 1'b0) begin n_fail++; $display("FAIL store_wait_ack got %b exp 0", l1d_ack); end
        mem_ack_val = 1; mem_ack_rdata = 32'h1234_5678;
        tick();
        mem_ack_val = 0; mem_req_rdy = 0;
        n_checks++; if ({l1i_ack, l1d_ack} !== 2'b01) begin n_fail++; $display("FAIL store_ack got i=%b d=%b exp 0/1", l1i_ack, l1d_ack); end
        l1d_req_val = 0;
        tick();
        n_checks++; if ({l1i_ack, l1d_ack} !== 2'b00) begin n_fail++; $display("FAIL store_single_ack got %b exp 00", {l1i_ack, l1d_ack}); end
    endtask

    task automatic test_tie();
        bit exp_d;
        do_reset();
        l1i_req_val = 1; l1i_req_addr = 32'h0000_1000;
        l1d_req_val = 1; l1d_req_addr = 32'h0000_2000; l1d_req_cop = 3'd0; l1d_req_size = 3'd2;
        mem_req_rdy = 1;
        exp_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = ref_pick_d(1'b1, 1'b1);
            tick();
            n_checks++; if ({mem_req_val, mem_req_addr} !== {1'b1, exp_d ? l1d_req_addr : l1i_req_addr}) begin
                n_fail++; $display("FAIL tie_grant_%0d got val=%b addr=%h exp winner %s", k, mem_req_val, mem_req_addr, exp_d ? "D" : "I");
            end
            tick();
            mem_ack_val = 1; mem_ack_rdata = 32'h5000 + 32'(k);
            tick();
            mem_ack_val = 0;
            n_checks++; if ({l1i_ack, l1d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL tie_ack_%0d got i=%b d=%b", k, l1i_ack, l1d_ack); end
            if (exp_d) begin
                if (k < 3) l1d_req_addr = l1d_req_addr + 32'd4; else l1d_req_val = 0;
            end else begin
                if (k < 3) l1i_req_addr = l1i_req_addr + 32'd4; else l1i_req_val = 0;
            end
            tick();
        end
        exp_d = ref_pick_d(l1i_req_val, l1d_req_val);
        tick();
        n_checks++; if ({mem_req_val, mem_req_addr} !== {1'b1, exp_d ? l1d_req_addr : l1i_req_addr}) begin
            n_fail++; $display("FAIL tie_leftover got val=%b addr=%h exp winner %s", mem_req_val, mem_req_addr, exp_d ? "D" : "I");
        end
        tick();
        mem_ack_val = 1;
        tick();
        mem_ack_val = 0;
        n_checks++; if ({l1i_ack, l1d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL tie_leftover_ack got i=%b d=%b", l1i_ack, l1d_ack); end
        l1i_req_val = 0; l1d_req_val = 0;
        tick();
    endtask

    task automatic test_nc();
        csr_nc_base = 32'h8000_0000; csr_nc_mask = 32'hF000_0000;
        l1d_req_val = 1; l1d_req_addr = 32'h8000_0010; l1d_req_cop = 3'd0; l1d_req_size = 3'd2; mem_req_rdy = 0;
        tick();
        n_checks++; if ({mem_req_val, mem_req_nc} !== 2'b11) begin n_fail++; $display("FAIL nc_in_window got val=%b nc=%b exp 1/1", mem_req_val, mem_req_nc); end
        csr_nc_base = 32'h0000_0000;
        tick();
        n_checks++; if (mem_req_nc !== 1'b1) begin n_fail++; $display("FAIL nc_latched got %b exp 1", mem_req_nc); end
        mem_req_rdy = 1;
        tick();
        mem_ack_val = 1;
        tick();
        mem_ack_val = 0; l1d_req_val = 0;
        csr_nc_base = 32'h8000_0000;
        tick();
        l1d_req_val = 1; l1d_req_addr = 32'h7000_0010;
        tick();
        n_checks++; if ({mem_req_val, mem_req_nc} !== 2'b10) begin n_fail++; $display("FAIL nc_out_window got val=%b nc=%b exp 1/0", mem_req_val, mem_req_nc); end
        tick();
        mem_ack_val = 1;
        tick();
        mem_ack_val = 0; l1d_req_val = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        l1d_req_val = 1; l1d_req_addr = 32'h0000_0300; l1d_req_cop = 3'd0; mem_req_rdy = 1;
        tick();
        tick();
        rst_n = 0;
        #1;
        n_checks++; if ({mem_req_val, l1i_ack, l1d_ack, mem_req_addr, mem_req_size} !== '0) begin
            n_fail++; $display("FAIL rst_mid_async got val=%b acks=%b addr=%h size=%0d exp all 0", mem_req_val, {l1i_ack, l1d_ack}, mem_req_addr, mem_req_size);
        end
        l1d_req_val = 0;
        tick();
        rst_n = 1;
        m_rr_d = 1'b1;
        tick(); tick();
        mem_ack_val = 1; mem_ack_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack_val = 0;
        n_checks++; if ({mem_req_val, l1i_ack, l1d_ack, l1i_ack_rdata, l1d_ack_rdata, mem_req_addr} !== '0) begin
            n_fail++; $display("FAIL rst_stray_ack got val=%b acks=%b rdata=%h/%h addr=%h exp all 0", mem_req_val, {l1i_ack, l1d_ack}, l1i_ack_rdata, l1d_ack_rdata, mem_req_addr);
        end
        tick();
        n_checks++; if ({l1i_ack, l1d_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_stray_ack2 got %b exp 00", {l1i_ack, l1d_ack}); end
        l1i_req_val = 1; l1i_req_addr = 32'h0000_0400;
        tick();
        n_checks++; if ({mem_req_val, mem_req_addr} !== {1'b1, 32'h0000_0400}) begin n_fail++; $display("FAIL rst_then_idle got val=%b addr=%h exp 1/00000400", mem_req_val, mem_req_addr); end
        tick();
        mem_ack_val = 1; mem_ack_rdata = 32'h0000_0077;
        tick();
        mem_ack_val = 0; l1i_req_val = 0;
        n_checks++; if ({l1i_ack, l1i_ack_rdata} !== {1'b1, 32'h0000_0077}) begin n_fail++; $display("FAIL rst_then_ack got ack=%b rdata=%h exp 1/00000077", l1i_ack, l1i_ack_rdata); end
        tick();
    endtask

    task automatic test_idle_ack();
        quiet_inputs();
        tick();
        mem_ack_val = 1; mem_ack_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack_val = 0;
        n_checks++; if ({mem_req_val, l1i_ack, l1d_ack} !== 3'b000) begin n_fail++; $display("FAIL idle_ack got %b exp 000", {mem_req_val, l1i_ack, l1d_ack}); end
        tick();
        n_checks++; if ({l1i_ack, l1d_ack} !== 2'b00) begin n_fail++; $display("FAIL idle_ack2 got %b exp 00", {l1i_ack, l1d_ack}); end
        l1d_req_val = 1; l1d_req_addr = 32'h0000_0500; mem_req_rdy = 1;
        tick();
        n_checks++; if ({mem_req_val, mem_req_addr} !== {1'b1, 32'h0000_0500}) begin n_fail++; $display("FAIL idle_ack_grant got val=%b addr=%h", mem_req_val, mem_req_addr); end
        tick();
        mem_ack_val = 1;
        tick();
        mem_ack_val = 0; l1d_req_val = 0;
        tick();
    endtask

    // Randomized traffic: the reference tracks one transaction's life (granted, issued, answered).
    task automatic test_random();
        bit          txn_live, txn_issued, txn_answered;
        bit          own_d, e_val, e_i_ack, e_d_ack, e_chk, e_nc;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [2:0]  e_cop, e_size;
        logic [31:0] masks [3];
        masks[0] = 32'hF000_0000; masks[1] = 32'hFFFF_0000; masks[2] = 32'h0000_0000;
        do_reset();
        txn_live = 0; txn_issued = 0; txn_answered = 0;
        own_d = 0; e_val = 0; e_i_ack = 0; e_d_ack = 0; e_chk = 0; e_nc = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_cop = '0; e_size = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            n_checks++; if (mem_req_val !== e_val) begin n_fail++; $display("FAIL rnd_val cyc=%0d got %b exp %b", cyc, mem_req_val, e_val); end
            if (e_val) begin
                n_checks++; if ({mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size, mem_req_nc} !== {e_addr, e_cop, e_wdata, e_size, e_nc}) begin
                    n_fail++; $display("FAIL rnd_fields cyc=%0d got %h/%0d/%h/%0d/%b exp %h/%0d/%h/%0d/%b", cyc, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size, mem_req_nc, e_addr, e_cop, e_wdata, e_size, e_nc);
                end
            end
            n_checks++; if ({l1i_ack, l1d_ack} !== {e_i_ack, e_d_ack}) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got i=%b d=%b exp i=%b d=%b", cyc, l1i_ack, l1d_ack, e_i_ack, e_d_ack); end
            if (e_i_ack) begin
                n_checks++; if (l1i_ack_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_i_rdata cyc=%0d got %h exp %h", cyc, l1i_ack_rdata, e_rdata); end
            end
            if (e_d_ack && e_chk) begin
                n_checks++; if (l1d_ack_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_d_rdata cyc=%0d got %h exp %h", cyc, l1d_ack_rdata, e_rdata); end
            end

            if (e_i_ack) l1i_req_val = 0;
            if (e_d_ack) l1d_req_val = 0;
            if ($urandom_range(0, 15) == 0) begin
                csr_nc_mask = masks[$urandom_range(0, 2)];
                csr_nc_base = $urandom;
            end
            if (!l1i_req_val && $urandom_range(0, 3) == 0) begin
                l1i_req_val  = 1;
                l1i_req_addr = $urandom_range(0, 1) ? {csr_nc_base[31:28], 28'($urandom)} : $urandom;
            end
            if (!l1d_req_val && $urandom_range(0, 3) == 0) begin
                l1d_req_val   = 1;
                l1d_req_addr  = $urandom_range(0, 1) ? {csr_nc_base[31:28], 28'($urandom)} : $urandom;
                l1d_req_cop   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
                l1d_req_wdata = $urandom;
                l1d_req_size  = 3'($urandom_range(0, 2));
            end
            mem_req_rdy   = ($urandom_range(0, 2) != 0);
            mem_ack_val   = ($urandom_range(0, 2) == 0);
            mem_ack_rdata = $urandom;

            e_i_ack = 0; e_d_ack = 0;
            if (txn_answered) begin
                txn_live = 0; txn_issued = 0; txn_answered = 0;
            end else if (!txn_live) begin
                if (l1i_req_val || l1d_req_val) begin
                    own_d   = ref_pick_d(l1i_req_val, l1d_req_val);
                    e_addr  = own_d ? l1d_req_addr : l1i_req_addr;
                    e_cop   = (own_d && l1d_req_cop == 3'd1) ? 3'd1 : 3'd0;
                    e_wdata = own_d ? l1d_req_wdata : 32'd0;
                    e_size  = own_d ? l1d_req_size : 3'd2;
                    e_nc    = ref_nc(e_addr, csr_nc_base, csr_nc_mask);
                    e_chk   = (e_cop == 3'd0);
                    txn_live = 1;
                    e_val    = 1;
                end
            end else if (!txn_issued) begin
                if (mem_req_rdy) begin
                    txn_issued = 1;
                    e_val      = 0;
                end
            end else if (mem_ack_val) begin
                e_rdata      = mem_ack_rdata;
                e_i_ack      = !own_d;
                e_d_ack      = own_d;
                txn_answered = 1;
            end
        end
        quiet_inputs();
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_stall();
        test_tie();
        test_nc();
        test_reset_mid();
        test_idle_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
